// File: rtl/speaker_sample_fifo.sv
// Speaker sample buffer: four-phase write handshake into a FIFO, drained one
// sample per synchronized rising edge of the external sample clock.
module speaker_sample_fifo #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clock_valid,
    input  logic                     sample_clock_in,
    input  logic                     write_request,
    input  logic [WIDTH-1:0]         write_data,
    output logic                     write_ack,
    output logic [WIDTH-1:0]         sample_out,
    output logic                     sample_strobe,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               underrun_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_ACKED
    } wr_state_t;

    wr_state_t              r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;

    logic w_tick;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Full/empty come from the pre-edge count, so a tick on a full FIFO
    // defers the push by a cycle and a push into an empty FIFO still underruns.
    always_comb begin
        w_tick  = r_sync[SYNC_STAGES-1] & ~r_hist & clock_valid;
        w_empty = (fifo_count == '0);
        w_full  = (fifo_count == FULL_COUNT);
        w_push  = (r_state == ST_IDLE) & write_request & ~w_full;
        w_pop   = w_tick & ~w_empty;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sample_clock_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            write_ack <= 1'b0;
            r_wr_ptr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_push) begin
                        r_wr_ptr  <= r_wr_ptr + 1'b1;
                        write_ack <= 1'b1;
                        r_state   <= ST_ACKED;
                    end
                end
                ST_ACKED: begin
                    if (!write_request) begin
                        write_ack <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    write_ack <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr       <= '0;
            sample_out     <= '0;
            sample_strobe  <= 1'b0;
            underrun_count <= '0;
        end else begin
            sample_strobe <= w_pop;
            if (w_pop) begin
                sample_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            if (w_tick && w_empty && (underrun_count != 8'hFF)) begin
                underrun_count <= underrun_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_speaker_sample_fifo.sv
// Directed and randomized checks of speaker_sample_fifo against a queue model.
module tb_speaker_sample_fifo;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 16;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             clock_valid;
    logic             sample_clock_in;
    logic             write_request;
    logic [WIDTH-1:0] write_data;
    logic             write_ack;
    logic [WIDTH-1:0] sample_out;
    logic             sample_strobe;
    logic [4:0]       fifo_count;
    logic [7:0]       underrun_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_sample;
    int unsigned      m_under;

    speaker_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .clock_valid    (clock_valid),
        .sample_clock_in(sample_clock_in),
        .write_request  (write_request),
        .write_data     (write_data),
        .write_ack      (write_ack),
        .sample_out     (sample_out),
        .sample_strobe  (sample_strobe),
        .fifo_count     (fifo_count),
        .underrun_count (underrun_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_sample = '0;
        m_under  = 0;
    endtask

    // All tasks begin and end 1 time unit after a rising clock edge.
    task automatic push(input logic [WIDTH-1:0] d, input int unsigned hold);
        bit got;
        got = 0;
        write_request = 1'b1;
        write_data    = d;
        for (int i = 0; i < 20; i++) begin
            step();
            if (write_ack) begin
                got = 1;
                break;
            end
        end
        check("push_ack", 32'(got), 32'd1);
        m_q.push_back(d);
        check("push_count", 32'(fifo_count), 32'(m_q.size()));
        for (int unsigned i = 0; i < hold; i++) begin
            step();
            check("hold_ack", 32'(write_ack), 32'd1);
            check("hold_count", 32'(fifo_count), 32'(m_q.size()));
        end
        write_request = 1'b0;
        step();
        check("ack_drop", 32'(write_ack), 32'd0);
    endtask

    task automatic tick(input bit valid);
        bit exp_strobe;
        clock_valid     = valid;
        sample_clock_in = 1'b1;
        step();
        step();
        check("strobe_early", 32'(sample_strobe), 32'd0);
        step();
        exp_strobe = 0;
        if (valid) begin
            if (m_q.size() > 0) begin
                m_sample   = m_q.pop_front();
                exp_strobe = 1;
            end else if (m_under < 255) begin
                m_under++;
            end
        end
        check("strobe", 32'(sample_strobe), 32'(exp_strobe));
        check("sample_out", 32'(sample_out), 32'(m_sample));
        check("underrun", 32'(underrun_count), m_under);
        check("tick_count", 32'(fifo_count), 32'(m_q.size()));
        step();
        check("strobe_len", 32'(sample_strobe), 32'd0);
        sample_clock_in = 1'b0;
        repeat (3) step();
        check("fall_no_strobe", 32'(sample_strobe), 32'd0);
        clock_valid = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] d17;
        bit               got;

        reset_n         = 1'b0;
        clock_valid     = 1'b1;
        sample_clock_in = 1'b0;
        write_request   = 1'b0;
        write_data      = '0;
        model_reset();
        repeat (3) step();
        check("rst_ack", 32'(write_ack), 32'd0);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_strobe", 32'(sample_strobe), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_under", 32'(underrun_count), 32'd0);
        reset_n = 1'b1;
        step();

        // Underruns on an empty FIFO
        repeat (3) tick(1'b1);

        // Two pushes drained in order
        push(16'h1234, 0);
        push(16'hBEEF, 0);
        tick(1'b1);
        tick(1'b1);

        // Long request writes one entry only
        push(16'hA5A5, 10);
        tick(1'b1);

        // Fill to DEPTH, then a 17th request waits for a pop
        for (int i = 0; i < DEPTH; i++) push(16'($urandom), 0);
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        d17           = 16'($urandom);
        write_request = 1'b1;
        write_data    = d17;
        for (int i = 0; i < 5; i++) begin
            step();
            check("full_no_ack", 32'(write_ack), 32'd0);
            check("full_hold", 32'(fifo_count), 32'(DEPTH));
        end
        sample_clock_in = 1'b1;
        step();
        step();
        step();
        m_sample = m_q.pop_front();
        check("full_pop_strobe", 32'(sample_strobe), 32'd1);
        check("full_pop_sample", 32'(sample_out), 32'(m_sample));
        check("full_pop_count", 32'(fifo_count), 32'(DEPTH - 1));
        check("full_pop_noack", 32'(write_ack), 32'd0);
        step();
        m_q.push_back(d17);
        check("full_late_ack", 32'(write_ack), 32'd1);
        check("full_refill", 32'(fifo_count), 32'(DEPTH));
        write_request   = 1'b0;
        sample_clock_in = 1'b0;
        step();
        check("full_ack_drop", 32'(write_ack), 32'd0);
        repeat (3) step();

        // Drain to four entries, then ticks with clock_valid low do nothing
        while (m_q.size() > 4) tick(1'b1);
        repeat (3) tick(1'b0);
        check("cv_count", 32'(fifo_count), 32'd4);

        // Randomized mix of pushes and ticks
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) != 0 && m_q.size() < DEPTH)
                push(16'($urandom), $urandom_range(0, 3));
            else
                tick($urandom_range(0, 5) != 0);
        end

        // Asynchronous reset in the middle of an acknowledged write
        while (m_q.size() < 5) push(16'($urandom), 0);
        while (m_q.size() > 5) tick(1'b1);
        if (sample_out == '0) begin
            push(16'h00FF, 0);
            tick(1'b1);
        end
        write_request = 1'b1;
        write_data    = 16'h5555;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (write_ack) begin
                got = 1;
                break;
            end
        end
        check("mid_ack", 32'(got), 32'd1);
        check("mid_count", 32'(fifo_count), 32'd6);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_ack", 32'(write_ack), 32'd0);
        check("async_count", 32'(fifo_count), 32'd0);
        check("async_sample", 32'(sample_out), 32'd0);
        check("async_under", 32'(underrun_count), 32'd0);
        write_request = 1'b0;
        model_reset();
        step();
        reset_n = 1'b1;
        step();

        // Underrun counter saturates at 255
        for (int i = 0; i < 258; i++) tick(1'b1);
        check("under_sat", 32'(underrun_count), 32'd255);

        push(16'hC0DE, 0);
        tick(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
